delay_latency_meter: RTL and testbench

Self-test stage wrapped around `delay_line`: it drives the delay line's `idata` and watches its `odata`. On request it flushes the line with zeros and injects a one-cycle all-ones marker word. It then counts clock cycles until the marker emerges, reporting the measured latency or a timeout. It is used for bring-up and as a built-in check that the configured `DELAY` matches the hardware.

---
 rtl/delay_latency_meter.sv | 107 ++++++++++
 tb/tb_delay_latency_meter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/delay_latency_meter.sv
// delay_latency_meter: measures the latency of an attached delay line
// by flushing it, injecting an all-ones marker and counting cycles.
module delay_latency_meter #(
  parameter int N        = 3,
  parameter int MAX_WAIT = 15,
  parameter int W        = $clog2(MAX_WAIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] odata_in,
  output logic [N-1:0] idata_out,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] latency,
  output logic         timeout
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    SEND,
    WAIT
  } state_t;

  localparam logic [N-1:0] MARKER  = '1;
  localparam logic [W-1:0] CNT_MAX = W'(MAX_WAIT);
  localparam logic [W-1:0] CNT_ONE = W'(1);

  state_t       state;
  logic [W-1:0] cnt;
  logic         hit;

  // Only a full all-ones word counts as the marker.
  assign hit = (odata_in == MARKER);

  // Measurement FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idata_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      latency   <= '0;
      timeout   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          idata_out <= '0;
          if (start) begin
            state   <= FLUSH;
            busy    <= 1'b1;
            cnt     <= '0;
            latency <= '0;
            timeout <= 1'b0;
          end
        end
        FLUSH: begin
          if (cnt == CNT_MAX) begin
            state     <= SEND;
            cnt       <= '0;
            idata_out <= MARKER;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        SEND: begin
          idata_out <= '0;
          if (hit) begin
            state   <= IDLE;
            latency <= '0;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state <= WAIT;
            cnt   <= CNT_ONE;
          end
        end
        WAIT: begin
          idata_out <= '0;
          if (hit) begin
            state   <= IDLE;
            latency <= cnt;
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
          end else if (cnt == CNT_MAX) begin
            state   <= IDLE;
            latency <= '0;
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_latency_meter.sv
// tb_delay_latency_meter: directed checks of the latency meter
// against behavioural delay lines (N=3 variable, N=1 fixed at 2).
module tb_delay_latency_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;

  logic [2:0] odata0;
  logic [2:0] idata0;
  logic       busy0, done0, to0;
  logic [3:0] lat0;

  logic [0:0] odata1;
  logic [0:0] idata1;
  logic       busy1, done1, to1;
  logic [3:0] lat1;

  int         dly = 4;
  logic       tie = 1'b0;
  logic [2:0] tie_val = 3'b000;
  logic       sel1 = 1'b0;

  logic [2:0] pipe0 [0:15];
  logic [0:0] pipe1 [0:1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  delay_latency_meter #(.N(3), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .start(start),
    .odata_in(odata0), .idata_out(idata0),
    .busy(busy0), .done(done0),
    .latency(lat0), .timeout(to0)
  );

  delay_latency_meter #(.N(1), .MAX_WAIT(15)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .odata_in(odata1), .idata_out(idata1),
    .busy(busy1), .done(done1),
    .latency(lat1), .timeout(to1)
  );

  always @(posedge clk) begin
    pipe0[0] <= idata0;
    for (int k = 1; k < 16; k++) pipe0[k] <= pipe0[k-1];
    pipe1[0] <= idata1;
    pipe1[1] <= pipe1[0];
  end

  always_comb begin
    odata0 = 3'b000;
    if (tie) odata0 = tie_val;
    else if (dly == 0) odata0 = idata0;
    else odata0 = pipe0[dly-1];
  end

  assign odata1 = pipe1[1];

  logic [2:0] idata_o;
  logic       busy_o, done_o, to_o;
  logic [3:0] lat_o;
  logic [2:0] marker_o;

  assign idata_o  = sel1 ? {2'b00, idata1} : idata0;
  assign busy_o   = sel1 ? busy1 : busy0;
  assign done_o   = sel1 ? done1 : done0;
  assign to_o     = sel1 ? to1 : to0;
  assign lat_o    = sel1 ? lat1 : lat0;
  assign marker_o = sel1 ? 3'b001 : 3'b111;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts in cycle 0 (caller's current cycle); returns in the done cycle.
  task automatic measure(input int exp_done, input int exp_lat,
                         input int exp_to, input int ra, input int rb);
    start = 1'b1;
    step();
    for (int c = 1; c <= exp_done; c++) begin
      start = (c == ra || c == rb);
      chk("busy", 32'(busy_o), 32'(c < exp_done));
      chk("done", 32'(done_o), 32'(c == exp_done));
      chk("idata", 32'(idata_o), (c == 17) ? 32'(marker_o) : 32'd0);
      if (c == exp_done) begin
        chk("latency", 32'(lat_o), 32'(exp_lat));
        chk("timeout", 32'(to_o), 32'(exp_to));
      end else begin
        step();
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_idata"}, 32'(idata0), 32'd0);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_done"}, 32'(done0), 32'd0);
    chk({tag, "_lat"}, 32'(lat0), 32'd0);
    chk({tag, "_to"}, 32'(to0), 32'd0);
    chk({tag, "_busy1"}, 32'(busy1), 32'd0);
    chk({tag, "_done1"}, 32'(done1), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_zero("reset");
    step();

    dly = 4;
    measure(22, 4, 0, -1, -1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_lat", 32'(lat0), 32'd4);
      chk("hold_done", 32'(done0), 32'd0);
      chk("hold_to", 32'(to0), 32'd0);
    end

    dly = 0;
    measure(18, 0, 0, -1, -1);
    dly = 15;
    measure(33, 15, 0, -1, -1);
    dly = 1;
    measure(19, 1, 0, -1, -1);

    tie = 1'b1;
    tie_val = 3'b000;
    measure(33, 0, 1, -1, -1);
    tie_val = 3'b110;
    measure(33, 0, 1, -1, -1);
    tie = 1'b0;

    dly = 4;
    measure(22, 4, 0, 5, 10);
    for (int i = 0; i < 30; i++) begin
      step();
      chk("no_requeue", 32'(done0 | busy0), 32'd0);
    end

    start = 1'b1;
    step();
    start = 1'b0;
    repeat (18) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("abort");
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort_done", 32'(done0 | done1), 32'd0);
    end
    measure(22, 4, 0, -1, -1);

    repeat (5) step();
    sel1 = 1'b1;
    measure(20, 2, 0, -1, -1);
    measure(20, 2, 0, -1, -1);
    step();
    chk("n1_done_clear", 32'(done1), 32'd0);
    chk("n1_hold_lat", 32'(lat1), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
